sobel_grad_pipe: RTL
====================

// Module: sobel_grad_pipe
// PURPOSE
//  Parametrised, pipelined successor to the single-stage Sobel edge stage. Accepts one 3x3 pixel
//  window per beat over a valid/ready handshake, computes |Gx|, |Gy| with signs, a selectable
//  magnitude (L1 or max), a programmable threshold decision and a running edge-pixel count.
//  Sits between the line-buffer/window generator and the SPI/output packer.
// PARAMETERS
//  PIX_W   8   pixel width, bits
//  CNT_W   20  edge counter width, bits
//  (derived) GRAD_W = PIX_W+2 (|Gx|,|Gy| width); MAG_W = PIX_W+3 (magnitude/threshold width)
// PORTS
//  clk        in   1          clock
//  reset      in   1          synchronous, active-high reset
//  in_valid   in   1          window valid
//  in_ready   out  1          block can accept window this cycle
//  win        in   9*PIX_W    window, row-major: [PIX_W-1:0]=p11 ... [9*PIX_W-1:8*PIX_W]=p33
//  mag_mode   in   1          0 = |Gx|+|Gy|, 1 = max(|Gx|,|Gy|); sampled with window
//  thresh     in   MAG_W      edge threshold; sampled with window
//  cnt_clr    in   1          clear edge counter
//  out_valid  out  1          result valid
//  out_ready  in   1          downstream accepts result
//  gx_mag     out  GRAD_W     |Gx|
//  gx_sign    out  1          1 when left column sum > right column sum
//  gy_mag     out  GRAD_W     |Gy|
//  gy_sign    out  1          1 when bottom row sum > top row sum
//  mag        out  MAG_W      magnitude per mag_mode
//  edge_pix   out  PIX_W      all-ones if mag >= thresh, else 0
//  edge_cnt   out  CNT_W      count of delivered beats with edge_pix != 0
// BEHAVIOUR
//  - Column sums L=p11+2*p21+p31, R=p13+2*p23+p33; row sums T=p11+2*p12+p13, B=p31+2*p32+p33.
//    All sums unsigned, GRAD_W bits, no overflow possible.
//  - gx_mag=|L-R|, gx_sign=(L>R); gy_mag=|B-T|, gy_sign=(B>T). Equal sums -> mag 0, sign 0.
//  - mag is zero-extended to MAG_W; L1 sum cannot overflow MAG_W. Compare mag>=thresh unsigned.
//  - 3 register stages: S1 capture window+mode+thresh, S2 sums/abs/sign, S3 mag/threshold.
//    Latency: beat accepted in cycle N appears on outputs in cycle N+3 when out_ready held high.
//  - Handshake: transfer when valid&&ready on either side. Global stall:
//    adv = !out_valid || out_ready; in_ready = adv; all stages advance only when adv.
//    Bubbles propagate as invalid stages. While out_valid && !out_ready all outputs hold stable.
//    in_ready may depend combinationally on out_ready; no other comb path in->out.
//  - Throughput 1 beat/cycle with out_ready high; no beat dropped or duplicated; order preserved.
//  - edge_cnt increments by 1 on each out_valid&&out_ready beat with edge_pix!=0; saturates at
//    all-ones. cnt_clr takes priority over a same-cycle increment (result 0).
//  - Reset (any cycle, incl. mid-stream): all stage valids 0, in-flight beats discarded; outputs
//    out_valid=0, gx/gy/mag/edge_pix/signs=0, edge_cnt=0. in_ready=1 in the first cycle after reset.
//  - Data outputs are registered and qualified by out_valid; they are 0 when out_valid=0.
// STRUCTURE
//  - Package sobel_pkg: MAG_L1=1'b0, MAG_MAX=1'b1; width helpers grad_w(PIX_W), mag_w(PIX_W).
//  - Sub-module sobel_axis_diff (#PIX_W): combinational 1-2-1 weighted sums of two pixel triples,
//    returns abs difference + sign; instantiated twice (X on columns, Y on rows) in S2.
//  - Top holds the three stage registers, stall logic and edge counter.
// TESTING (PIX_W=8, thresh=255 unless stated, out_ready=1 unless stated)
//  1 Vertical step: left column 255, rest 0 -> gx_mag=1020, gx_sign=1, gy_mag=0, mag=1020,
//    edge_pix=255, exactly 3 cycles after accept; edge_cnt=1.
//  2 Flat window all 100 -> gx_mag=gy_mag=mag=0, signs 0, edge_pix=0, edge_cnt unchanged.
//  3 Only p33=80, thresh=100: mode L1 -> gx=80 s0, gy=80 s1, mag=160, edge_pix=255;
//    mode max -> mag=80, edge_pix=0.
//  4 Back-pressure: stream 6 distinct windows, drop out_ready for 5 cycles mid-stream ->
//    outputs stable while stalled, in_ready=0, all 6 results delivered in order, none repeated.
//  5 Reset asserted with 3 beats in flight -> next cycle out_valid=0, edge_cnt=0, in_ready=1;
//    no stale beat emerges afterwards.
//  6 CNT_W=3: 9 edge beats -> edge_cnt saturates at 7; cnt_clr coincident with an edge beat -> 0.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared constants and width helpers for the Sobel gradient pipeline.
package sobel_pkg;

    localparam logic MAG_L1  = 1'b0;
    localparam logic MAG_MAX = 1'b1;

    function automatic int unsigned grad_w(input int unsigned pix_w);
        return pix_w + 2;
    endfunction

    function automatic int unsigned mag_w(input int unsigned pix_w);
        return pix_w + 3;
    endfunction

endpackage

// File: rtl/sobel_axis_diff.sv
// Combinational 1-2-1 weighted sums of two pixel triples; returns |a - b| and sign (a > b).
module sobel_axis_diff
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    localparam int unsigned GRAD_W = grad_w(PIX_W)
) (
    input  logic [PIX_W-1:0]  a0,
    input  logic [PIX_W-1:0]  a1,
    input  logic [PIX_W-1:0]  a2,
    input  logic [PIX_W-1:0]  b0,
    input  logic [PIX_W-1:0]  b1,
    input  logic [PIX_W-1:0]  b2,
    output logic [GRAD_W-1:0] diff_mag,
    output logic              diff_sign
);

    logic [GRAD_W-1:0] sum_a;
    logic [GRAD_W-1:0] sum_b;

    always_comb begin
        sum_a     = GRAD_W'(a0) + (GRAD_W'(a1) << 1) + GRAD_W'(a2);
        sum_b     = GRAD_W'(b0) + (GRAD_W'(b1) << 1) + GRAD_W'(b2);
        diff_sign = sum_a > sum_b;
        diff_mag  = diff_sign ? (sum_a - sum_b) : (sum_b - sum_a);
    end

endmodule

// File: rtl/sobel_grad_pipe.sv
// Three-stage Sobel gradient pipeline with global stall, magnitude select, threshold and
// saturating edge-pixel counter.
module sobel_grad_pipe
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned CNT_W = 20,
    localparam int unsigned GRAD_W = grad_w(PIX_W),
    localparam int unsigned MAG_W  = mag_w(PIX_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [9*PIX_W-1:0] win,
    input  logic               mag_mode,
    input  logic [MAG_W-1:0]   thresh,
    input  logic               cnt_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [GRAD_W-1:0]  gx_mag,
    output logic               gx_sign,
    output logic [GRAD_W-1:0]  gy_mag,
    output logic               gy_sign,
    output logic [MAG_W-1:0]   mag,
    output logic [PIX_W-1:0]   edge_pix,
    output logic [CNT_W-1:0]   edge_cnt
);

    logic adv;

    logic               s1_valid;
    logic [9*PIX_W-1:0] s1_win;
    logic               s1_mode;
    logic [MAG_W-1:0]   s1_thresh;

    logic              s2_valid;
    logic [GRAD_W-1:0] s2_gx;
    logic              s2_gx_sign;
    logic [GRAD_W-1:0] s2_gy;
    logic              s2_gy_sign;
    logic              s2_mode;
    logic [MAG_W-1:0]  s2_thresh;

    logic [PIX_W-1:0]  pix [9];
    logic [GRAD_W-1:0] gx_c;
    logic              gx_sign_c;
    logic [GRAD_W-1:0] gy_c;
    logic              gy_sign_c;
    logic [MAG_W-1:0]  mag_c;
    logic              edge_c;

    // Single stall signal: every stage moves together when the output slot frees up.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar i = 0; i < 9; i++) begin : g_pix
        assign pix[i] = s1_win[i*PIX_W +: PIX_W];
    end

    // X: left column vs right column; Y: bottom row vs top row.
    sobel_axis_diff #(.PIX_W(PIX_W)) u_diff_x (
        .a0        (pix[0]),
        .a1        (pix[3]),
        .a2        (pix[6]),
        .b0        (pix[2]),
        .b1        (pix[5]),
        .b2        (pix[8]),
        .diff_mag  (gx_c),
        .diff_sign (gx_sign_c)
    );

    sobel_axis_diff #(.PIX_W(PIX_W)) u_diff_y (
        .a0        (pix[6]),
        .a1        (pix[7]),
        .a2        (pix[8]),
        .b0        (pix[0]),
        .b1        (pix[1]),
        .b2        (pix[2]),
        .diff_mag  (gy_c),
        .diff_sign (gy_sign_c)
    );

    always_comb begin
        if (s2_mode == MAG_MAX) begin
            mag_c = (s2_gx >= s2_gy) ? MAG_W'(s2_gx) : MAG_W'(s2_gy);
        end else begin
            mag_c = MAG_W'(s2_gx) + MAG_W'(s2_gy);
        end
        edge_c = mag_c >= s2_thresh;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_win     <= '0;
            s1_mode    <= 1'b0;
            s1_thresh  <= '0;
            s2_valid   <= 1'b0;
            s2_gx      <= '0;
            s2_gx_sign <= 1'b0;
            s2_gy      <= '0;
            s2_gy_sign <= 1'b0;
            s2_mode    <= 1'b0;
            s2_thresh  <= '0;
            out_valid  <= 1'b0;
            gx_mag     <= '0;
            gx_sign    <= 1'b0;
            gy_mag     <= '0;
            gy_sign    <= 1'b0;
            mag        <= '0;
            edge_pix   <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_win    <= win;
                s1_mode   <= mag_mode;
                s1_thresh <= thresh;
            end
            s2_valid   <= s1_valid;
            s2_gx      <= gx_c;
            s2_gx_sign <= gx_sign_c;
            s2_gy      <= gy_c;
            s2_gy_sign <= gy_sign_c;
            s2_mode    <= s1_mode;
            s2_thresh  <= s1_thresh;
            out_valid  <= s2_valid;
            // Bubbles zero the data outputs so they are only non-zero under out_valid.
            if (s2_valid) begin
                gx_mag   <= s2_gx;
                gx_sign  <= s2_gx_sign;
                gy_mag   <= s2_gy;
                gy_sign  <= s2_gy_sign;
                mag      <= mag_c;
                edge_pix <= edge_c ? {PIX_W{1'b1}} : '0;
            end else begin
                gx_mag   <= '0;
                gx_sign  <= 1'b0;
                gy_mag   <= '0;
                gy_sign  <= 1'b0;
                mag      <= '0;
                edge_pix <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            edge_cnt <= '0;
        end else if (out_valid && out_ready && (edge_pix != '0) && (edge_cnt != '1)) begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

endmodule
